// File: rtl/multicycle_control.sv
// Moore controller for the multicycle datapath: one state per datapath step,
// with strobes decoded from the state register and blanked while reset is high.
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE        = 6'h00,
    parameter logic [5:0] OP_LW           = 6'h23,
    parameter logic [5:0] OP_SW           = 6'h2B,
    parameter logic [5:0] OP_BEQ          = 6'h04,
    parameter logic [5:0] OP_J            = 6'h02,
    parameter logic [5:0] OP_ADDI         = 6'h08,
    parameter bit         HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opCode,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        FETCH      = 4'd0,
        FETCH_WAIT = 4'd1,
        DECODE     = 4'd2,
        MEM_ADDR   = 4'd3,
        MEM_READ   = 4'd4,
        MEM_WB     = 4'd5,
        MEM_WRITE  = 4'd6,
        EXECUTE    = 4'd7,
        R_WB       = 4'd8,
        BRANCH     = 4'd9,
        JUMP       = 4'd10,
        ADDI_EXEC  = 4'd11,
        ADDI_WB    = 4'd12,
        HALT       = 4'd13
    } state_t;

    state_t state_reg;
    logic   illegal_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= FETCH;
            illegal_reg <= 1'b0;
        end else begin
            case (state_reg)
                FETCH:      state_reg <= FETCH_WAIT;
                FETCH_WAIT: state_reg <= DECODE;
                DECODE: begin
                    if (opCode == OP_LW || opCode == OP_SW) begin
                        state_reg <= MEM_ADDR;
                    end else if (opCode == OP_RTYPE) begin
                        state_reg <= EXECUTE;
                    end else if (opCode == OP_BEQ) begin
                        state_reg <= BRANCH;
                    end else if (opCode == OP_J) begin
                        state_reg <= JUMP;
                    end else if (opCode == OP_ADDI) begin
                        state_reg <= ADDI_EXEC;
                    end else begin
                        illegal_reg <= 1'b1;
                        if (HALT_ON_ILLEGAL) begin
                            state_reg <= HALT;
                        end else begin
                            state_reg <= FETCH;
                        end
                    end
                end
                MEM_ADDR: begin
                    // opCode is still held by the IR; only LW/SW can reach here
                    if (opCode == OP_LW) begin
                        state_reg <= MEM_READ;
                    end else if (opCode == OP_SW) begin
                        state_reg <= MEM_WRITE;
                    end else begin
                        state_reg <= FETCH;
                    end
                end
                MEM_READ:   state_reg <= MEM_WB;
                EXECUTE:    state_reg <= R_WB;
                ADDI_EXEC:  state_reg <= ADDI_WB;
                HALT:       state_reg <= HALT;
                MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, ADDI_WB: state_reg <= FETCH;
                default:    state_reg <= FETCH;
            endcase
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        case (state_reg)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = 1'b1;
            end
            FETCH_WAIT: begin
                IRWrite = 1'b1;
                MemRead = 1'b1;
            end
            DECODE: ALUSrcB = 2'b11;
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEM_READ: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            MEM_WB: begin
                IorD       = 1'b1;
                MemRead    = 1'b1;
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            MEM_WRITE: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                instr_done = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            R_WB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
            JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDI_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // Blank every strobe during reset so no write escapes mid-instruction
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            MemtoReg    = 1'b0;
            IRWrite     = 1'b0;
            ALUSrcA     = 1'b0;
            RegWrite    = 1'b0;
            RegDst      = 1'b0;
            ALUOp       = 2'b00;
            ALUSrcB     = 2'b00;
            PCSource    = 2'b00;
            instr_done  = 1'b0;
        end
    end

    assign state      = state_reg;
    assign illegal_op = illegal_reg & ~reset;

endmodule
